// File: rtl/mem_port_arbiter.sv
// Two-port (fetch + load/store) front end over one shared word RAM with fixed access latency.
// Define MEM_PORT_ARBITER_RR_EN for round-robin conflict arbitration (default: DATA wins).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_enable,
  output logic              instr_valid,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [31:0]       instr_result,
  input  logic              data_enable,
  output logic              data_valid,
  input  logic [1:0]        data_oplen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic              data_rw,
  output logic [31:0]       data_rdata
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              sel_data_q;
  logic              pend_i_q, pend_d_q;
  logic              instr_valid_q, data_valid_q;
  logic [31:0]       instr_result_q, data_rdata_q;
  logic [IdxW-1:0]   i_idx_q, d_idx_q;
  logic [1:0]        d_lo_q, d_oplen_q;
  logic [31:0]       d_wdata_q;
  logic              d_rw_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              done, grant_data, mem_we;
  logic [IdxW-1:0]   rd_idx;
  logic [31:0]       rd_word, byte_sh, half_sh, load_val, wr_data;
  logic [3:0]        wr_be;

  logic unused_addr;
  assign unused_addr = ^{instr_addr[ADDR_W-1:IdxW+2], instr_addr[1:0],
                         data_addr[ADDR_W-1:IdxW+2]};

`ifdef MEM_PORT_ARBITER_RR_EN
  logic last_data_q;
  // On conflict, favour the port that did not win the previous grant.
  assign grant_data = pend_d_q && !(pend_i_q && last_data_q);
`else
  assign grant_data = pend_d_q;
`endif

  assign done   = (state_q == StBusy) && (cnt_q == '0);
  assign mem_we = done && sel_data_q && d_rw_q;
  assign rd_idx = sel_data_q ? d_idx_q : i_idx_q;

  always_comb begin
    rd_word  = mem[rd_idx];
    byte_sh  = rd_word >> {d_lo_q, 3'b000};
    half_sh  = rd_word >> {d_lo_q[1], 4'b0000};
    load_val = rd_word;
    wr_be    = 4'hF;
    wr_data  = d_wdata_q;
    case (d_oplen_q)
      2'b00: begin
        load_val = {24'h0, byte_sh[7:0]};
        wr_be    = 4'b0001 << d_lo_q;
        wr_data  = {4{d_wdata_q[7:0]}};
      end
      2'b01: begin
        load_val = {16'h0, half_sh[15:0]};
        wr_be    = d_lo_q[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{d_wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM is deliberately left out of reset; writes commit only on a store's completion edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[d_idx_q][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      sel_data_q     <= 1'b0;
      pend_i_q       <= 1'b0;
      pend_d_q       <= 1'b0;
      instr_valid_q  <= 1'b1;
      data_valid_q   <= 1'b1;
      instr_result_q <= '0;
      data_rdata_q   <= '0;
      i_idx_q        <= '0;
      d_idx_q        <= '0;
      d_lo_q         <= '0;
      d_oplen_q      <= '0;
      d_wdata_q      <= '0;
      d_rw_q         <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
      last_data_q    <= 1'b0;
`endif
    end else begin
      if (instr_enable && instr_valid_q) begin
        i_idx_q       <= instr_addr[IdxW+1:2];
        pend_i_q      <= 1'b1;
        instr_valid_q <= 1'b0;
      end
      if (data_enable && data_valid_q) begin
        d_idx_q      <= data_addr[IdxW+1:2];
        d_lo_q       <= data_addr[1:0];
        d_oplen_q    <= data_oplen;
        d_wdata_q    <= data_wdata;
        d_rw_q       <= data_rw;
        pend_d_q     <= 1'b1;
        data_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (pend_i_q || pend_d_q) begin
            state_q    <= StBusy;
            sel_data_q <= grant_data;
            cnt_q      <= CntW'(LATENCY - 1);
`ifdef MEM_PORT_ARBITER_RR_EN
            last_data_q <= grant_data;
`endif
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StIdle;
            if (sel_data_q) begin
              pend_d_q     <= 1'b0;
              data_valid_q <= 1'b1;
              if (!d_rw_q) data_rdata_q <= load_val;
            end else begin
              pend_i_q       <= 1'b0;
              instr_valid_q  <= 1'b1;
              instr_result_q <= rd_word;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_valid  = instr_valid_q;
  assign instr_result = instr_result_q;
  assign data_valid   = data_valid_q;
  assign data_rdata   = data_rdata_q;

endmodule
